mem_access_unit: RTL and testbench

Load/store sequencer between the CPU datapath and the word-wide data memory. Accepts byte, halfword and word load/store requests. Drives the memory's word address, write data and write enable. Because the memory reads synchronously and writes only whole words, sub-word stores are done as read-modify-write, and sub-word loads are extracted and extended from the returned word.

---
 rtl/mau_pkg.sv | 31 +++
 rtl/mau_byte_lane.sv | 64 ++++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, lane width.
// Build option MAU_MISALIGN_TRAP_EN is consumed by mem_access_unit, not here.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LANE_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } mau_state_t;

    // Size 11 has no aligned form, so it always counts as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [LANE_W-1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mau_byte_lane.sv
// Combinational lane logic: extracts and extends a load result from a memory word,
// and merges store data into that word for read-modify-write.
module mau_byte_lane
    import mau_pkg::*;
(
    input  logic [31:0]       i_word,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_load,
    output logic [31:0]       o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: pick the addressed lane and extend to 32 bits.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_load = i_word;
        case (i_lane)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        if (i_lane[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the word just read.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'b00:   o_merged[7:0]   = i_wdata[7:0];
                    2'b01:   o_merged[15:8]  = i_wdata[7:0];
                    2'b10:   o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a synchronous word-wide memory; sub-word stores use RMW.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned requests instead of aligning them down.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    mau_state_t        r_state;
    mau_state_t        w_next;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [LANE_W-1:0] r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mis;

    logic              w_accept;
    logic              w_mis;
    logic [1:0]        w_size_eff;
    logic [ADDR_W-1:0] w_addr_eff;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign req_ready    = (r_state == IDLE);
    assign rsp_valid    = (r_state == RESP);
    assign mem_we       = (r_state == WRITE);
    assign mem_addr     = r_addr;
    assign mem_wd       = r_wd;
    assign rsp_rdata    = r_rdata;
    assign rsp_misalign = r_mis;

`ifdef MAU_MISALIGN_TRAP_EN
    // Classify the incoming request; misaligned ones go straight to RESP.
    always_comb begin
        w_size_eff = req_size;
        w_addr_eff = req_addr;
        w_mis      = is_misaligned(req_size, req_addr[1:0]);
    end
`else
    // Align the address down to the access size; size 11 behaves as a word.
    always_comb begin
        w_size_eff = req_size;
        w_addr_eff = req_addr;
        w_mis      = 1'b0;
        case (req_size)
            SZ_BYTE: w_addr_eff = req_addr;
            SZ_HALF: w_addr_eff[0] = 1'b0;
            default: begin
                w_size_eff      = SZ_WORD;
                w_addr_eff[1:0] = 2'b00;
            end
        endcase
    end
`endif

    mau_byte_lane u_lane (
        .i_word   (mem_rd),
        .i_lane   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_accept) begin
                    w_next = IDLE;
                end else if (w_mis) begin
                    w_next = RESP;
                end else if (req_write && (w_size_eff == SZ_WORD)) begin
                    w_next = WRITE;
                end else begin
                    w_next = READ;
                end
            end
            READ:  w_next = CAPT;
            CAPT: begin
                if (r_write) begin
                    w_next = WRITE;
                end else begin
                    w_next = RESP;
                end
            end
            WRITE: w_next = RESP;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, memory-side registers and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_lane   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wd     <= '0;
            r_rdata  <= '0;
            r_mis    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_size   <= w_size_eff;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_rdata  <= '0;
                        r_mis    <= w_mis;
                        // A rejected request leaves the memory address untouched.
                        if (!w_mis) begin
                            r_addr <= {w_addr_eff[ADDR_W-1:2], 2'b00};
                            r_lane <= w_addr_eff[1:0];
                            if (req_write && (w_size_eff == SZ_WORD)) begin
                                r_wd <= req_wdata;
                            end
                        end
                    end
                end
                CAPT: begin
                    if (r_write) begin
                        r_wd <= w_merged;
                    end else begin
                        r_rdata <= w_load;
                    end
                end
                default: r_mis <= r_mis;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a synchronous word memory model.
// Behaviour under MAU_MISALIGN_TRAP_EN is checked when the macro is defined.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    int n_cmp;
    int n_fail;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr[7:2]] <= mem_wd;
        mem_rd <= mem[mem_addr[7:2]];
    end

    // Issue one request from a negedge in IDLE and observe it until rsp_valid (bounded).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output int rc, output logic [31:0] rd, output logic mis,
                          output int wec, output int wecyc, output logic [31:0] wea,
                          output logic [31:0] wewd, output logic hs_ok);
        @(negedge clk);
        rc = -1; rd = 32'h0; mis = 1'b0; wec = 0; wecyc = -1; wea = 32'h0; wewd = 32'h0;
        hs_ok = (req_ready === 1'b1) && (rsp_valid === 1'b0);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        for (int k = 1; k <= 8 && rc < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready !== 1'b0) hs_ok = 1'b0;
            if (mem_we === 1'b1) begin
                wec++; wecyc = k; wea = mem_addr; wewd = mem_wd;
            end
            if (rsp_valid === 1'b1) begin
                rc = k; rd = rsp_rdata; mis = rsp_misalign;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        n_cmp++; if (rsp_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", rsp_misalign); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        n_cmp++; if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_wd got=%h exp=0", mem_wd); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || mem[4] !== 32'h8899AABB) begin
            n_fail++; $display("FAIL reset_ignored_req ready=%b word10=%h exp 1/8899aabb", req_ready, mem[4]);
        end
    endtask

    task automatic test_loads();
        int rc, wec, wecyc; logic [31:0] rd, wea, wewd; logic mis, ok;
        logic [1:0]  sz [0:5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        sg [0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [0:5] = '{32'h11, 32'h10, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] ex [0:5] = '{32'hFFFFFFAA, 32'h000000BB, 32'h00000088,
                                  32'h00008899, 32'hFFFF8899, 32'h8899AABB};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
            n_cmp++; if (rd !== ex[i] || rc != 3 || wec != 0 || mis !== 1'b0 || !ok) begin
                n_fail++;
                $display("FAIL load_%0d got data=%h cyc=%0d we=%0d mis=%b hs=%b exp data=%h cyc=3 we=0 mis=0 hs=1",
                         i, rd, rc, wec, mis, ok, ex[i]);
            end
        end
    endtask

    task automatic test_misalign();
        int rc, wec, wecyc; logic [31:0] rd, wea, wewd; logic mis, ok;
`ifdef MAU_MISALIGN_TRAP_EN
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rc != 1 || mis !== 1'b1 || wec != 0 || rd !== 32'h0 || !ok) begin
            n_fail++; $display("FAIL trap_half got cyc=%0d mis=%b we=%0d data=%h exp 1/1/0/0", rc, mis, wec, rd);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rc != 1 || mis !== 1'b1 || wec != 0 || mem[4] !== 32'h8899AABB) begin
            n_fail++; $display("FAIL trap_size3 got cyc=%0d mis=%b we=%0d word=%h exp 1/1/0/8899aabb", rc, mis, wec, mem[4]);
        end
`else
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rc != 3 || mis !== 1'b0 || rd !== 32'h0000AABB) begin
            n_fail++; $display("FAIL align_half got cyc=%0d mis=%b data=%h exp 3/0/0000aabb", rc, mis, rd);
        end
        do_req(1'b0, 2'b11, 1'b0, 32'h13, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rc != 3 || mis !== 1'b0 || rd !== 32'h8899AABB) begin
            n_fail++; $display("FAIL align_size3 got cyc=%0d mis=%b data=%h exp 3/0/8899aabb", rc, mis, rd);
        end
`endif
    endtask

    task automatic test_store_subword();
        int rc, wec, wecyc; logic [31:0] rd, wea, wewd; logic mis, ok;
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005C, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (wec != 1 || wecyc != 3 || wea !== 32'h10 || wewd !== 32'h5C99AABB) begin
            n_fail++; $display("FAIL sb_write got n=%0d cyc=%0d addr=%h wd=%h exp 1/3/10/5c99aabb", wec, wecyc, wea, wewd);
        end
        n_cmp++; if (rc != 4 || rd !== 32'h0 || !ok) begin
            n_fail++; $display("FAIL sb_rsp got cyc=%0d data=%h hs=%b exp 4/0/1", rc, rd, ok);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rd !== 32'h5C99AABB || rc != 3) begin
            n_fail++; $display("FAIL sb_reload got data=%h cyc=%0d exp 5c99aabb/3", rd, rc);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (wec != 1 || wewd !== 32'h5C99BEEF || rc != 4) begin
            n_fail++; $display("FAIL sh_write got n=%0d wd=%h cyc=%0d exp 1/5c99beef/4", wec, wewd, rc);
        end
    endtask

    task automatic test_store_word();
        int rc, wec, wecyc; logic [31:0] rd, wea, wewd; logic mis, ok;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (wec != 1 || wecyc != 1 || wea !== 32'h20 || wewd !== 32'h12345678 || rc != 2) begin
            n_fail++; $display("FAIL sw got n=%0d wecyc=%0d addr=%h wd=%h rsp=%0d exp 1/1/20/12345678/2", wec, wecyc, wea, wewd, rc);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rd !== 32'h12345678) begin
            n_fail++; $display("FAIL sw_reload got=%h exp=12345678", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rd !== 32'h00000056) begin
            n_fail++; $display("FAIL sw_byte1 got=%h exp=00000056", rd);
        end
    endtask

    task automatic test_reset_abort();
        int rc, wec, wecyc; logic [31:0] rd, wea, wewd; logic mis, ok;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000077;
        for (int k = 1; k <= 6 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_we === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL abort_reach_write got=0 exp=1"); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_async got we=%b ready=%b exp 0/1", mem_we, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem[4] !== 32'h5C99BEEF || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_state got word=%h ready=%b rsp=%b exp 5c99beef/1/0", mem[4], req_ready, rsp_valid);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rd, mis, wec, wecyc, wea, wewd, ok);
        n_cmp++; if (rd !== 32'h5C99BEEF || rc != 3) begin
            n_fail++; $display("FAIL abort_reload got data=%h cyc=%0d exp 5c99beef/3", rd, rc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_loads();
        test_misalign();
        test_store_subword();
        test_store_word();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
